// File: rtl/cricket_pkg.sv
// Shared encodings for the cricket scoring blocks: game state, delivery extra type
// and innings end reason, plus the legal-delivery classification.
package cricket_pkg;

  typedef enum logic [1:0] {
    GS_IDLE     = 2'd0,
    GS_ACTIVE   = 2'd1,
    GS_COMPLETE = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    XT_NONE    = 2'd0,
    XT_WIDE    = 2'd1,
    XT_NO_BALL = 2'd2,
    XT_BYE     = 2'd3
  } extra_type_t;

  typedef enum logic [1:0] {
    END_NONE    = 2'd0,
    END_OVERS   = 2'd1,
    END_ALL_OUT = 2'd2,
    END_TARGET  = 2'd3
  } end_reason_t;

  function automatic logic is_legal(input extra_type_t xt);
    return (xt == XT_NONE) || (xt == XT_BYE);
  endfunction

endpackage

// File: rtl/innings_scoreboard_over_counter.sv
// Legal-ball and over counting with wrap detection and a registered one-cycle
// over_complete pulse; overs_next_o exposes the post-update over count.
module over_counter #(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             legal_i,
  output logic [$clog2(BALLS_PER_OVER)-1:0] balls_o,
  output logic [$clog2(MAX_OVERS+1)-1:0]    overs_o,
  output logic [$clog2(MAX_OVERS+1)-1:0]    overs_next_o,
  output logic                             over_complete_o
);

  localparam int BALL_W = $clog2(BALLS_PER_OVER);
  localparam int OVER_W = $clog2(MAX_OVERS + 1);
  localparam logic [BALL_W-1:0] LAST_BALL = BALL_W'(BALLS_PER_OVER - 1);

  logic [BALL_W-1:0] balls_q, balls_d;
  logic [OVER_W-1:0] overs_q, overs_d;
  logic              oc_q, oc_d;

  always_comb begin
    balls_d = balls_q;
    overs_d = overs_q;
    oc_d    = 1'b0;
    if (clear_i) begin
      balls_d = '0;
      overs_d = '0;
    end else if (legal_i) begin
      if (balls_q == LAST_BALL) begin
        balls_d = '0;
        overs_d = overs_q + OVER_W'(1);
        oc_d    = 1'b1;
      end else begin
        balls_d = balls_q + BALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      balls_q <= '0;
      overs_q <= '0;
      oc_q    <= 1'b0;
    end else begin
      balls_q <= balls_d;
      overs_q <= overs_d;
      oc_q    <= oc_d;
    end
  end

  assign balls_o         = balls_q;
  assign overs_o         = overs_q;
  assign overs_next_o    = overs_d;
  assign over_complete_o = oc_q;

endmodule

// File: rtl/innings_scoreboard.sv
// Single-innings scoreboard: runs, extras, wickets, chase target and completion FSM.
// Optional free-hit tracking is enabled by defining INNINGS_FREE_HIT_EN.
module innings_scoreboard
  import cricket_pkg::*;
#(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int MAX_WICKETS    = 10,
  parameter int RUN_W          = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_innings,
  input  logic [RUN_W-1:0]                  target,
  input  logic                              ball_bowled,
  input  logic [2:0]                        runs_scored,
  input  logic [1:0]                        extra_type,
  input  logic                              wicket_fallen,
  output logic [$clog2(BALLS_PER_OVER)-1:0] balls,
  output logic [$clog2(MAX_OVERS+1)-1:0]    overs,
  output logic [RUN_W-1:0]                  total_runs,
  output logic [RUN_W-1:0]                  extras,
  output logic [$clog2(MAX_WICKETS+1)-1:0]  wickets,
  output logic [1:0]                        game_state,
  output logic                              innings_active,
  output logic                              over_complete,
  output logic [1:0]                        end_reason
`ifdef INNINGS_FREE_HIT_EN
  ,
  output logic                              free_hit
`endif
);

  localparam int OVER_W = $clog2(MAX_OVERS + 1);
  localparam int WKT_W  = $clog2(MAX_WICKETS + 1);

  game_state_t       state_q, state_d;
  end_reason_t       end_q, end_d;
  logic [RUN_W-1:0]  total_q, total_d;
  logic [RUN_W-1:0]  extras_q, extras_d;
  logic [RUN_W-1:0]  target_q, target_d;
  logic [WKT_W-1:0]  wkts_q, wkts_d;
  logic [OVER_W-1:0] overs_next;

  extra_type_t xt;
  logic        start_acc;
  logic        deliver;
  logic        legal;
  logic        wicket_eff;
  logic [3:0]  add_runs;

  function automatic logic [RUN_W-1:0] sat_add(input logic [RUN_W-1:0] a, input logic [3:0] b);
    logic [RUN_W:0] sum;
    sum = {1'b0, a} + (RUN_W+1)'(b);
    return sum[RUN_W] ? '1 : sum[RUN_W-1:0];
  endfunction

  assign xt        = extra_type_t'(extra_type);
  assign start_acc = start_innings && (state_q != GS_ACTIVE);
  assign deliver   = ball_bowled && (state_q == GS_ACTIVE);
  assign legal     = deliver && is_legal(xt);
  assign add_runs  = {1'b0, runs_scored} + {3'b000, (xt == XT_WIDE) || (xt == XT_NO_BALL)};

`ifdef INNINGS_FREE_HIT_EN
  logic fh_q, fh_d;
  assign wicket_eff = wicket_fallen && !fh_q;
  assign free_hit   = fh_q;
`else
  assign wicket_eff = wicket_fallen;
`endif

  over_counter #(
    .BALLS_PER_OVER(BALLS_PER_OVER),
    .MAX_OVERS     (MAX_OVERS)
  ) u_over_counter (
    .clk_i          (clk),
    .rst_ni         (reset),
    .clear_i        (start_acc),
    .legal_i        (legal),
    .balls_o        (balls),
    .overs_o        (overs),
    .overs_next_o   (overs_next),
    .over_complete_o(over_complete)
  );

  always_comb begin
    state_d  = state_q;
    end_d    = end_q;
    total_d  = total_q;
    extras_d = extras_q;
    target_d = target_q;
    wkts_d   = wkts_q;
`ifdef INNINGS_FREE_HIT_EN
    fh_d     = fh_q;
`endif
    if (start_acc) begin
      state_d  = GS_ACTIVE;
      end_d    = END_NONE;
      total_d  = '0;
      extras_d = '0;
      wkts_d   = '0;
      target_d = target;
`ifdef INNINGS_FREE_HIT_EN
      fh_d     = 1'b0;
`endif
    end else if (deliver) begin
      total_d = sat_add(total_q, add_runs);
      if (xt != XT_NONE) extras_d = sat_add(extras_q, add_runs);
      if (wicket_eff && (wkts_q != WKT_W'(MAX_WICKETS))) wkts_d = wkts_q + WKT_W'(1);
`ifdef INNINGS_FREE_HIT_EN
      if (xt == XT_NO_BALL) fh_d = 1'b1;
      else if (legal)       fh_d = 1'b0;
`endif
      // Completion looks at post-delivery values so the final ball is counted.
      if ((target_q != '0) && (total_d >= target_q)) begin
        state_d = GS_COMPLETE;
        end_d   = END_TARGET;
      end else if (wkts_d == WKT_W'(MAX_WICKETS)) begin
        state_d = GS_COMPLETE;
        end_d   = END_ALL_OUT;
      end else if (overs_next == OVER_W'(MAX_OVERS)) begin
        state_d = GS_COMPLETE;
        end_d   = END_OVERS;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= GS_IDLE;
      end_q    <= END_NONE;
      total_q  <= '0;
      extras_q <= '0;
      target_q <= '0;
      wkts_q   <= '0;
`ifdef INNINGS_FREE_HIT_EN
      fh_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      end_q    <= end_d;
      total_q  <= total_d;
      extras_q <= extras_d;
      target_q <= target_d;
      wkts_q   <= wkts_d;
`ifdef INNINGS_FREE_HIT_EN
      fh_q     <= fh_d;
`endif
    end
  end

  assign total_runs     = total_q;
  assign extras         = extras_q;
  assign wickets        = wkts_q;
  assign game_state     = state_q;
  assign innings_active = (state_q == GS_ACTIVE);
  assign end_reason     = end_q;

endmodule

// File: tb/tb_innings_scoreboard.sv
// Self-checking bench for innings_scoreboard: directed table, corner sequences and
// randomized deliveries against a ball-count based reference model.
module tb_innings_scoreboard;

  localparam int BPO  = 6;
  localparam int MO   = 2;
  localparam int MW   = 3;
  localparam int RW   = 10;
  localparam int MAXR = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_innings = 1'b0;
  logic [RW-1:0] target = '0;
  logic          ball_bowled = 1'b0;
  logic [2:0]    runs_scored = '0;
  logic [1:0]    extra_type = '0;
  logic          wicket_fallen = 1'b0;
  logic [2:0]    balls;
  logic [1:0]    overs;
  logic [RW-1:0] total_runs;
  logic [RW-1:0] extras;
  logic [1:0]    wickets;
  logic [1:0]    game_state;
  logic          innings_active;
  logic          over_complete;
  logic [1:0]    end_reason;
`ifdef INNINGS_FREE_HIT_EN
  logic          free_hit;
`endif

  innings_scoreboard #(
    .BALLS_PER_OVER(BPO),
    .MAX_OVERS     (MO),
    .MAX_WICKETS   (MW),
    .RUN_W         (RW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_innings (start_innings),
    .target        (target),
    .ball_bowled   (ball_bowled),
    .runs_scored   (runs_scored),
    .extra_type    (extra_type),
    .wicket_fallen (wicket_fallen),
    .balls         (balls),
    .overs         (overs),
    .total_runs    (total_runs),
    .extras        (extras),
    .wickets       (wickets),
    .game_state    (game_state),
    .innings_active(innings_active),
    .over_complete (over_complete),
    .end_reason    (end_reason)
`ifdef INNINGS_FREE_HIT_EN
    ,
    .free_hit      (free_hit)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: innings tracked as a count of legal balls plus plain totals.
  int m_state, m_legal, m_total, m_extras, m_wkts, m_end, m_target, m_oc;
  bit m_fh;

  task automatic model_reset();
    m_state = 0; m_legal = 0; m_total = 0; m_extras = 0;
    m_wkts = 0; m_end = 0; m_target = 0; m_oc = 0; m_fh = 1'b0;
  endtask

  task automatic model_step(input bit st, input int tgt, input bit bb, input int rs,
                            input int xt, input bit wk);
    int  add;
    bit  lgl, honour;
    m_oc = 0;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_legal = 0; m_total = 0; m_extras = 0; m_wkts = 0;
        m_end = 0; m_target = tgt; m_fh = 1'b0;
      end
    end else if (bb) begin
      add = rs + ((xt == 1 || xt == 2) ? 1 : 0);
      m_total = (m_total + add > MAXR) ? MAXR : m_total + add;
      if (xt != 0) m_extras = (m_extras + add > MAXR) ? MAXR : m_extras + add;
      lgl = (xt == 0 || xt == 3);
      if (lgl) begin
        m_legal++;
        if (m_legal % BPO == 0) m_oc = 1;
      end
      honour = 1'b1;
`ifdef INNINGS_FREE_HIT_EN
      honour = !m_fh;
      if (xt == 2) m_fh = 1'b1;
      else if (lgl) m_fh = 1'b0;
`endif
      if (wk && honour && m_wkts < MW) m_wkts++;
      if (m_target != 0 && m_total >= m_target) m_end = 3;
      else if (m_wkts == MW) m_end = 2;
      else if (m_legal / BPO == MO) m_end = 1;
      if (m_end != 0) m_state = 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".balls"},   32'(balls),          m_legal % BPO);
    chk({tag, ".overs"},   32'(overs),          m_legal / BPO);
    chk({tag, ".total"},   32'(total_runs),     m_total);
    chk({tag, ".extras"},  32'(extras),         m_extras);
    chk({tag, ".wickets"}, 32'(wickets),        m_wkts);
    chk({tag, ".state"},   32'(game_state),     m_state);
    chk({tag, ".active"},  32'(innings_active), (m_state == 1) ? 1 : 0);
    chk({tag, ".over_complete"}, 32'(over_complete), m_oc);
    chk({tag, ".end"},     32'(end_reason),     m_end);
`ifdef INNINGS_FREE_HIT_EN
    chk({tag, ".free_hit"}, 32'(free_hit),      m_fh ? 1 : 0);
`endif
  endtask

  task automatic step(input string tag, input bit st, input int tgt, input bit bb,
                      input int rs, input int xt, input bit wk);
    start_innings = st;
    target        = RW'(tgt);
    ball_bowled   = bb;
    runs_scored   = 3'(rs);
    extra_type    = 2'(xt);
    wicket_fallen = wk;
    @(posedge clk);
    model_step(st, tgt, bb, rs, xt, wk);
    #1;
    start_innings = 1'b0;
    ball_bowled   = 1'b0;
    wicket_fallen = 1'b0;
    check_all(tag);
  endtask

  typedef struct {
    bit st; int tgt; bit bb; int rs; int xt; bit wk;
    int e_balls; int e_overs; int e_total; int e_extras; int e_wkts; int e_state; int e_end;
  } vec_t;

  vec_t tbl[10];
  int   oc_seen;

  initial begin
    // start + delivery in same IDLE cycle: delivery dropped
    tbl[0] = '{1, 0, 1, 4, 0, 1,  0, 0,  0, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 1, 1, 0, 0,  1, 0,  1, 0, 0, 1, 0};
    tbl[2] = '{0, 0, 1, 0, 0, 0,  2, 0,  1, 0, 0, 1, 0};
    tbl[3] = '{0, 0, 1, 4, 0, 0,  3, 0,  5, 0, 0, 1, 0};
    tbl[4] = '{0, 0, 1, 2, 0, 0,  4, 0,  7, 0, 0, 1, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 1,  5, 0,  7, 0, 1, 1, 0};
    tbl[6] = '{0, 0, 1, 6, 0, 0,  0, 1, 13, 0, 1, 1, 0};
    tbl[7] = '{0, 0, 1, 0, 1, 0,  0, 1, 14, 1, 1, 1, 0};
    tbl[8] = '{0, 0, 1, 4, 2, 0,  0, 1, 19, 6, 1, 1, 0};
    tbl[9] = '{0, 0, 1, 0, 0, 0,  1, 1, 19, 6, 1, 1, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    step("idle_ball", 0, 0, 1, 3, 0, 0);

    oc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].st, tbl[i].tgt, tbl[i].bb, tbl[i].rs, tbl[i].xt, tbl[i].wk);
      oc_seen += int'(over_complete);
      chk($sformatf("tbl%0d.c_balls", i),  32'(balls),      tbl[i].e_balls);
      chk($sformatf("tbl%0d.c_overs", i),  32'(overs),      tbl[i].e_overs);
      chk($sformatf("tbl%0d.c_total", i),  32'(total_runs), tbl[i].e_total);
      chk($sformatf("tbl%0d.c_extras", i), 32'(extras),     tbl[i].e_extras);
      chk($sformatf("tbl%0d.c_wkts", i),   32'(wickets),    tbl[i].e_wkts);
      chk($sformatf("tbl%0d.c_state", i),  32'(game_state), tbl[i].e_state);
      chk($sformatf("tbl%0d.c_end", i),    32'(end_reason), tbl[i].e_end);
    end
    chk("over_complete_count", 32'(oc_seen), 1);

    // Innings runs out of overs; further deliveries ignored.
    for (int i = 0; i < 5; i++) step("overs_run", 0, 0, 1, 0, 0, 0);
    chk("overs_limit.overs", 32'(overs), 2);
    chk("overs_limit.balls", 32'(balls), 0);
    chk("overs_limit.state", 32'(game_state), 2);
    chk("overs_limit.end",   32'(end_reason), 1);
    step("after_complete", 0, 0, 1, 4, 0, 1);
    chk("after_complete.total", 32'(total_runs), 19);

    // All out inside the first over, then restart.
    step("restart1", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("all_out", 0, 0, 1, 1, 0, 1);
    chk("all_out.end",   32'(end_reason), 2);
    chk("all_out.balls", 32'(balls), 3);
    chk("all_out.wkts",  32'(wickets), 3);
    step("restart2", 1, 0, 0, 0, 0, 0);
    chk("restart2.wkts",  32'(wickets), 0);
    chk("restart2.total", 32'(total_runs), 0);

    // Asynchronous reset mid-innings with a delivery in flight.
    step("pre_reset", 0, 0, 1, 2, 0, 0);
    ball_bowled = 1'b1; runs_scored = 3'd4;
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1 check_all("held_reset");
    ball_bowled = 1'b0;
    reset = 1'b1;

    // Chase of 10 reached with 6 then 4.
    step("chase_start", 1, 10, 0, 0, 0, 0);
    step("chase6", 0, 0, 1, 6, 0, 0);
    chk("chase6.state", 32'(game_state), 1);
    step("chase4", 0, 0, 1, 4, 0, 0);
    chk("chase.total", 32'(total_runs), 10);
    chk("chase.end",   32'(end_reason), 3);

    // Final ball reaches target, third wicket and last over together: TARGET wins.
    step("prio_start", 1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step("prio_dot", 0, 0, 1, 0, 0, (i == 3 || i == 7));
    step("prio_last", 0, 0, 1, 6, 0, 1);
    chk("prio.end",  32'(end_reason), 3);
    chk("prio.wkts", 32'(wickets), 3);

    // Free hit: no-ball, wide, then wicket ball, then wicket ball.
    step("fh_start", 1, 0, 0, 0, 0, 0);
    step("fh_nb", 0, 0, 1, 0, 2, 0);
    step("fh_wide", 0, 0, 1, 0, 1, 0);
    step("fh_wkt1", 0, 0, 1, 0, 0, 1);
`ifdef INNINGS_FREE_HIT_EN
    chk("fh_wkt1.wkts", 32'(wickets), 0);
    chk("fh_wkt1.free_hit", 32'(free_hit), 0);
`else
    chk("fh_wkt1.wkts", 32'(wickets), 1);
`endif
    step("fh_wkt2", 0, 0, 1, 0, 0, 1);
`ifdef INNINGS_FREE_HIT_EN
    chk("fh_wkt2.wkts", 32'(wickets), 1);
`else
    chk("fh_wkt2.wkts", 32'(wickets), 2);
`endif

    // Run counters saturate.
    for (int i = 0; i < 130; i++) step("sat_wide", 0, 0, 1, 7, 1, 0);
    chk("sat.total",  32'(total_runs), MAXR);
    chk("sat.extras", 32'(extras), MAXR);
    step("sat_bat", 0, 0, 1, 7, 0, 0);
    chk("sat_bat.total", 32'(total_runs), MAXR);

    // Randomized deliveries and restarts.
    for (int i = 0; i < 3000; i++) begin
      int tgt;
      tgt = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 60));
      step("rnd", ($urandom % 8) == 0, tgt, ($urandom % 4) != 0, int'($urandom % 8),
           int'($urandom % 4), ($urandom % 6) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
